// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode/execute control FSM driving the PC jump unit
//
// Purpose:
//   Fetches a 20-bit instruction into the IR, decodes it and steps through
//   FETCH -> DECODE -> EXEC (-> MEM_WAIT | HALT) -> FETCH. Each instruction
//   moves the PC exactly once through a single non-zero o_CJ cycle.
//
// Ports:
//   Clk, Rst          clock (rising edge), asynchronous active-low reset
//   i_Instr[19:0]     instruction bus: OP[19:16] Rd[15:12] Rs[11:8] Imm[7:0]
//   i_Run             fetch enable, looked at only in FETCH
//   i_Resume          leave HALT, looked at only in HALT
//   i_Mem_Ack         data-memory access complete
//   o_CJ[3:0]         PC control code (0000 hold, 0001 increment, 1xxx load)
//   o_Rx_Sel[3:0]     IR Rs field: jump target / memory address register
//   o_Rd_Sel[3:0]     IR Rd field: destination / store-source register
//   o_Imm[7:0]        IR immediate field
//   o_Alu_Func[3:0]   IR Imm[3:0]
//   o_Reg_We          register write strobe
//   o_Imm_Sel         write-back source is o_Imm
//   o_Mem_Req         data-memory request
//   o_Mem_We          data-memory write qualifier
//   o_Illegal         one-cycle pulse on reserved opcode
//   o_Bus_Err         sticky memory-timeout flag
//   o_Halted          high while halted
//   o_Retired         wrapping count of completed instructions

module instr_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [19:0]      i_Instr,
    input  logic             i_Run,
    input  logic             i_Resume,
    input  logic             i_Mem_Ack,
    output logic [3:0]       o_CJ,
    output logic [3:0]       o_Rx_Sel,
    output logic [3:0]       o_Rd_Sel,
    output logic [7:0]       o_Imm,
    output logic [3:0]       o_Alu_Func,
    output logic             o_Reg_We,
    output logic             o_Imm_Sel,
    output logic             o_Mem_Req,
    output logic             o_Mem_We,
    output logic             o_Illegal,
    output logic             o_Bus_Err,
    output logic             o_Halted,
    output logic [CNT_W-1:0] o_Retired
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0] CJ_HOLD = 4'b0000;
    localparam logic [3:0] CJ_INC  = 4'b0001;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ALU  = 4'b0001;
    localparam logic [3:0] OP_LDI  = 4'b0010;
    localparam logic [3:0] OP_LD   = 4'b0011;
    localparam logic [3:0] OP_STR  = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b0101;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [19:0]        ir_q, ir_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic               bus_err_q, bus_err_d;

    logic [3:0]         op;
    logic               op_jump;
    logic               op_reserved;
    logic               retire;
    logic [TMO_W-1:0]   tmo_inc;

    assign op          = ir_q[19:16];
    assign op_jump     = op[3];
    assign op_reserved = (op == 4'b0110) || (op == 4'b0111);
    assign tmo_inc     = tmo_q + 1'b1;

    // Operand fields come straight from the IR so the datapath sees them
    // for the whole life of the instruction.
    assign o_Rx_Sel   = ir_q[11:8];
    assign o_Rd_Sel   = ir_q[15:12];
    assign o_Imm      = ir_q[7:0];
    assign o_Alu_Func = ir_q[3:0];
    assign o_Bus_Err  = bus_err_q;
    assign o_Retired  = retired_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            tmo_q     <= '0;
            retired_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            tmo_q     <= tmo_d;
            retired_q <= retired_d;
            bus_err_q <= bus_err_d;
        end
    end

    // All strobes are decoded from the registered state, so an asynchronous
    // reset (state -> FETCH) removes o_Mem_Req without waiting for a clock.
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        tmo_d      = tmo_q;
        bus_err_d  = bus_err_q;
        retire     = 1'b0;
        o_CJ       = CJ_HOLD;
        o_Reg_We   = 1'b0;
        o_Imm_Sel  = 1'b0;
        o_Mem_Req  = 1'b0;
        o_Mem_We   = 1'b0;
        o_Illegal  = 1'b0;
        o_Halted   = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (i_Run) begin
                    ir_d    = i_Instr;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                o_Illegal = op_reserved;
                state_d   = S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                if (op_jump) begin
                    // Condition flags are evaluated by the jump unit.
                    o_CJ   = op;
                    retire = 1'b1;
                end else begin
                    case (op)
                        OP_ALU: begin
                            o_Reg_We = 1'b1;
                            o_CJ     = CJ_INC;
                            retire   = 1'b1;
                        end
                        OP_LDI: begin
                            o_Reg_We  = 1'b1;
                            o_Imm_Sel = 1'b1;
                            o_CJ      = CJ_INC;
                            retire    = 1'b1;
                        end
                        OP_LD, OP_STR: begin
                            o_Mem_Req = 1'b1;
                            o_Mem_We  = (op == OP_STR);
                            tmo_d     = '0;
                            state_d   = S_MEM_WAIT;
                        end
                        OP_HALT: begin
                            retire  = 1'b1;
                            state_d = S_HALT;
                        end
                        default: begin
                            // NOP and the reserved opcodes just step the PC.
                            o_CJ   = CJ_INC;
                            retire = 1'b1;
                        end
                    endcase
                end
            end

            S_MEM_WAIT: begin
                o_Mem_Req = 1'b1;
                o_Mem_We  = (op == OP_STR);
                tmo_d     = tmo_inc;
                // Ack is tested first so a same-cycle ack at the limit wins.
                if (i_Mem_Ack) begin
                    o_CJ     = CJ_INC;
                    o_Reg_We = (op == OP_LD);
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if (tmo_inc == TMO_W'(MEM_TIMEOUT)) begin
                    bus_err_d = 1'b1;
                    o_CJ      = CJ_INC;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end
            end

            S_HALT: begin
                o_Halted = 1'b1;
                if (i_Resume) begin
                    // HALT already retired; this only moves the PC past it.
                    o_CJ    = CJ_INC;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase

        retired_d = retired_q + CNT_W'(retire);
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer

module tb_instr_sequencer;

    localparam int CNT_W = 4;

    logic             Clk;
    logic             Rst;
    logic [19:0]      i_Instr;
    logic             i_Run;
    logic             i_Resume;
    logic             i_Mem_Ack;
    logic [3:0]       o_CJ;
    logic [3:0]       o_Rx_Sel;
    logic [3:0]       o_Rd_Sel;
    logic [7:0]       o_Imm;
    logic [3:0]       o_Alu_Func;
    logic             o_Reg_We;
    logic             o_Imm_Sel;
    logic             o_Mem_Req;
    logic             o_Mem_We;
    logic             o_Illegal;
    logic             o_Bus_Err;
    logic             o_Halted;
    logic [CNT_W-1:0] o_Retired;

    instr_sequencer #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_Instr    (i_Instr),
        .i_Run      (i_Run),
        .i_Resume   (i_Resume),
        .i_Mem_Ack  (i_Mem_Ack),
        .o_CJ       (o_CJ),
        .o_Rx_Sel   (o_Rx_Sel),
        .o_Rd_Sel   (o_Rd_Sel),
        .o_Imm      (o_Imm),
        .o_Alu_Func (o_Alu_Func),
        .o_Reg_We   (o_Reg_We),
        .o_Imm_Sel  (o_Imm_Sel),
        .o_Mem_Req  (o_Mem_Req),
        .o_Mem_We   (o_Mem_We),
        .o_Illegal  (o_Illegal),
        .o_Bus_Err  (o_Bus_Err),
        .o_Halted   (o_Halted),
        .o_Retired  (o_Retired)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] cj;
        logic       reg_we;
        logic       imm_sel;
        logic       mem_req;
        logic       mem_we;
        logic [3:0] rx;
        logic [3:0] rd;
        logic [7:0] imm;
        logic [3:0] alu;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    int cj_cnt     = 0;
    int memreq_cnt = 0;
    int regwe_cnt  = 0;
    int ill_cnt    = 0;

    logic [CNT_W-1:0] exp_ret = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] cj, input logic we, input logic isel,
                                input logic mreq, input logic mwe, input logic [3:0] rx,
                                input logic [3:0] rd, input logic [7:0] imm, input logic [3:0] alu);
        exp_t e;
        e = '{cj, we, isel, mreq, mwe, rx, rd, imm, alu};
        return e;
    endfunction

    // Monitor: every non-zero o_CJ cycle is one PC move and consumes one
    // expected record.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                if (o_Mem_Req) memreq_cnt++;
                if (o_Reg_We)  regwe_cnt++;
                if (o_Illegal) ill_cnt++;
                if (o_CJ != 4'b0000) begin
                    cj_cnt++;
                    a = '{o_CJ, o_Reg_We, o_Imm_Sel, o_Mem_Req, o_Mem_We,
                          o_Rx_Sel, o_Rd_Sel, o_Imm, o_Alu_Func};
                    if (sb_q.size() == 0) begin
                        check("unexpected_cj", 64'(a), 64'(0));
                    end else begin
                        e = sb_q.pop_front();
                        check("cj_cycle", 64'(a), 64'(e));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [19:0] ins);
        i_Instr = ins;
        i_Run   = 1'b1;
        tick();
        i_Run   = 1'b0;
        i_Instr = 20'h0;
    endtask

    // Waits from DECODE for the PC-move cycle; optionally raises i_Mem_Ack
    // for one cycle. n counts cycles from DECODE up to the o_CJ cycle.
    task automatic wait_cj(input int ack_at, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (n == ack_at) i_Mem_Ack = 1'b1;
            @(negedge Clk);
            n++;
            if (o_CJ != 4'b0000) done = 1'b1;
            tick();
            i_Mem_Ack = 1'b0;
        end
        if (!done) check("cj_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_op(input string name, input logic [19:0] ins, input exp_t e,
                          input int ack_at, input int exp_cycles, input int exp_mreq,
                          input int exp_we, input int exp_ill, input logic exp_berr);
        int m0, w0, i0, n;
        m0 = memreq_cnt;
        w0 = regwe_cnt;
        i0 = ill_cnt;
        sb_q.push_back(e);
        issue(ins);
        wait_cj(ack_at, n);
        exp_ret = exp_ret + 1'b1;
        check({name, "_cycles"},  64'(n + 1), 64'(exp_cycles));
        check({name, "_memreq"},  64'(memreq_cnt - m0), 64'(exp_mreq));
        check({name, "_regwe"},   64'(regwe_cnt - w0), 64'(exp_we));
        check({name, "_illegal"}, 64'(ill_cnt - i0), 64'(exp_ill));
        check({name, "_retired"}, 64'(o_Retired), 64'(exp_ret));
        check({name, "_buserr"},  64'(o_Bus_Err), 64'(exp_berr));
    endtask

    initial begin
        bit ok;
        int c0;
        Rst = 1'b0; i_Instr = 20'h0; i_Run = 1'b0; i_Resume = 1'b0; i_Mem_Ack = 1'b0;
        repeat (2) tick();
        check("reset_outputs",
              64'({o_CJ, o_Rx_Sel, o_Rd_Sel, o_Imm, o_Alu_Func, o_Reg_We, o_Imm_Sel,
                   o_Mem_Req, o_Mem_We, o_Illegal, o_Bus_Err, o_Halted, o_Retired}), 64'(0));
        Rst = 1'b1;
        tick();

        run_op("alu",  20'h10235, mk(4'h1, 1, 0, 0, 0, 4'h2, 4'h0, 8'h35, 4'h5), -1, 3, 0, 1, 0, 0);
        repeat (3) tick();
        check("idle_ir_hold", 64'({o_Rd_Sel, o_Rx_Sel, o_Alu_Func}), 64'(12'h025));
        run_op("jz",   20'hA0300, mk(4'hA, 0, 0, 0, 0, 4'h3, 4'h0, 8'h00, 4'h0), -1, 3, 0, 0, 0, 0);
        run_op("jmp",  20'h80700, mk(4'h8, 0, 0, 0, 0, 4'h7, 4'h0, 8'h00, 4'h0), -1, 3, 0, 0, 0, 0);
        run_op("jnc",  20'hD5A3C, mk(4'hD, 0, 0, 0, 0, 4'hA, 4'h5, 8'h3C, 4'hC), -1, 3, 0, 0, 0, 0);
        run_op("ldi",  20'h2C4AB, mk(4'h1, 1, 1, 0, 0, 4'h4, 4'hC, 8'hAB, 4'hB), -1, 3, 0, 1, 0, 0);
        run_op("ld",   20'h31400, mk(4'h1, 1, 0, 1, 0, 4'h4, 4'h1, 8'h00, 4'h0),  3, 5, 3, 1, 0, 0);
        run_op("str",  20'h42500, mk(4'h1, 0, 0, 1, 1, 4'h5, 4'h2, 8'h00, 4'h0),  3, 5, 3, 0, 0, 0);
        run_op("ack_at_limit", 20'h3B100, mk(4'h1, 1, 0, 1, 0, 4'h1, 4'hB, 8'h00, 4'h0), 16, 18, 16, 1, 0, 0);
        run_op("ld_timeout",   20'h37E00, mk(4'h1, 0, 0, 1, 0, 4'hE, 4'h7, 8'h00, 4'h0), -1, 18, 16, 0, 0, 1);

        // HALT: retires in EXEC, then waits for i_Resume.
        sb_q.push_back(mk(4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00, 4'h0));
        issue(20'h50000);
        tick();
        tick();
        exp_ret = exp_ret + 1'b1;
        check("halt_retired", 64'(o_Retired), 64'(exp_ret));
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (!(o_Halted && o_CJ == 4'b0000)) ok = 1'b0;
            tick();
        end
        check("halt_hold_10", 64'(ok), 64'(1));
        i_Resume = 1'b1;
        @(negedge Clk);
        check("resume_cycle_halted", 64'(o_Halted), 64'(1));
        tick();
        i_Resume = 1'b0;
        check("after_resume_halted", 64'(o_Halted), 64'(0));
        check("after_resume_retired", 64'(o_Retired), 64'(exp_ret));
        check("bus_err_sticky", 64'(o_Bus_Err), 64'(1));

        c0 = cj_cnt;
        i_Resume = 1'b1;
        repeat (3) tick();
        i_Resume = 1'b0;
        check("resume_ignored_fetch", 64'(cj_cnt - c0), 64'(0));

        run_op("reserved", 20'h60000, mk(4'h1, 0, 0, 0, 0, 4'h0, 4'h0, 8'h00, 4'h0), -1, 3, 0, 0, 1, 1);

        // NOPs carry the 4-bit retire counter across its wrap.
        for (int i = 0; i < 8; i++) begin
            logic [3:0] f;
            f = 4'(i + 3);
            run_op("nop", {4'h0, f, ~f, f, 4'h9},
                   mk(4'h1, 0, 0, 0, 0, ~f, f, {f, 4'h9}, 4'h9), -1, 3, 0, 0, 0, 1);
        end

        // Asynchronous reset in MEM_WAIT.
        issue(20'h31400);
        tick();
        tick();
        #2;
        check("memwait_req", 64'(o_Mem_Req), 64'(1));
        Rst = 1'b0;
        #1;
        check("async_reset_outputs",
              64'({o_CJ, o_Rx_Sel, o_Rd_Sel, o_Imm, o_Alu_Func, o_Reg_We, o_Imm_Sel,
                   o_Mem_Req, o_Mem_We, o_Illegal, o_Bus_Err, o_Halted, o_Retired}), 64'(0));
        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
